// File: rtl/sram_1rw1r_access_ctrl_pkg.sv
// rtl/sram_1rw1r_access_ctrl_pkg.sv - shared widths, owner encoding and pipeline tag for the 1RW1R scheduler
package sram_1rw1r_access_ctrl_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_write;
    } tag_t;

endpackage

// File: rtl/sram_1rw1r_access_ctrl_if.sv
// rtl/sram_1rw1r_access_ctrl_if.sv - requester A/B (port 0) and C (port 1) request/response bundle
interface sram_1rw1r_access_ctrl_if;
    import sram_1rw1r_access_ctrl_pkg::*;

    logic                  a_valid, a_ready, a_we, a_rsp_valid;
    logic [NUM_WMASKS-1:0] a_wmask;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata, a_rsp_rdata;

    logic                  b_valid, b_ready, b_we, b_rsp_valid;
    logic [NUM_WMASKS-1:0] b_wmask;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata, b_rsp_rdata;

    logic                  c_valid, c_ready, c_rsp_valid;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_rsp_rdata;

    modport slave (
        input  a_valid, a_we, a_wmask, a_addr, a_wdata,
        output a_ready, a_rsp_valid, a_rsp_rdata,
        input  b_valid, b_we, b_wmask, b_addr, b_wdata,
        output b_ready, b_rsp_valid, b_rsp_rdata,
        input  c_valid, c_addr,
        output c_ready, c_rsp_valid, c_rsp_rdata
    );

    modport master (
        output a_valid, a_we, a_wmask, a_addr, a_wdata,
        input  a_ready, a_rsp_valid, a_rsp_rdata,
        output b_valid, b_we, b_wmask, b_addr, b_wdata,
        input  b_ready, b_rsp_valid, b_rsp_rdata,
        output c_valid, c_addr,
        input  c_ready, c_rsp_valid, c_rsp_rdata
    );

endinterface

// File: rtl/sram_1rw1r_access_ctrl_arb.sv
// rtl/sram_1rw1r_access_ctrl_arb.sv - 2-way round-robin arbiter with last-grant pointer
module sram_1rw1r_access_ctrl_arb (
    input  logic clk,
    input  logic rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_en,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    // 1 when B won the last arbitration; resets to 1 so A wins the first tie.
    logic r_last_b;

    always_comb begin
        o_gnt_a = i_en & i_req_a & (~i_req_b | r_last_b);
        o_gnt_b = i_en & i_req_b & (~i_req_a | ~r_last_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_b <= 1'b1;
        end else if (o_gnt_a | o_gnt_b) begin
            r_last_b <= o_gnt_b;
        end
    end

endmodule

// File: rtl/sram_1rw1r_access_ctrl.sv
// rtl/sram_1rw1r_access_ctrl.sv - 1RW1R macro scheduler: RR on port 0, dedicated reader on port 1
module sram_1rw1r_access_ctrl
    import sram_1rw1r_access_ctrl_pkg::*;
(
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    sram_1rw1r_access_ctrl_if.slave  req,
    output logic                     sram_csb0,
    output logic                     sram_web0,
    output logic [NUM_WMASKS-1:0]    sram_wmask0,
    output logic [ADDR_WIDTH-1:0]    sram_addr0,
    output logic [DATA_WIDTH-1:0]    sram_din0,
    input  logic [DATA_WIDTH-1:0]    sram_dout0,
    output logic                     sram_csb1,
    output logic [ADDR_WIDTH-1:0]    sram_addr1,
    input  logic [DATA_WIDTH-1:0]    sram_dout1
);

    logic                  w_gnt_a, w_gnt_b, w_gnt, w_we, w_hazard, w_c_acc;
    logic [NUM_WMASKS-1:0] w_wmask;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    logic                  r_csb0, r_web0, r_csb1;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0, r_addr1;
    logic [DATA_WIDTH-1:0] r_din0;
    tag_t                  r_tag0, r_tag1;
    logic                  r_c_v0, r_c_v1;
    logic                  r_a_rsp_valid, r_b_rsp_valid, r_c_rsp_valid;
    logic [DATA_WIDTH-1:0] r_a_rsp_rdata, r_b_rsp_rdata, r_c_rsp_rdata;

    sram_1rw1r_access_ctrl_arb u_arb (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_req_a (req.a_valid),
        .i_req_b (req.b_valid),
        .i_en    (1'b1),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    assign w_gnt = w_gnt_a | w_gnt_b;

    always_comb begin
        w_we    = req.a_we;
        w_wmask = req.a_wmask;
        w_addr  = req.a_addr;
        w_wdata = req.a_wdata;
        if (w_gnt_b) begin
            w_we    = req.b_we;
            w_wmask = req.b_wmask;
            w_addr  = req.b_addr;
            w_wdata = req.b_wdata;
        end
    end

    // A port-1 read of the word port 0 is writing this cycle would race the write; hold C off.
    assign w_hazard = w_gnt & w_we & (w_addr == req.c_addr);
    assign w_c_acc  = req.c_valid & ~w_hazard;

    assign req.a_ready = w_gnt_a;
    assign req.b_ready = w_gnt_b;
    assign req.c_ready = w_c_acc;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_csb0   <= 1'b1;
            r_web0   <= 1'b1;
            r_wmask0 <= '0;
            r_addr0  <= '0;
            r_din0   <= '0;
            r_csb1   <= 1'b1;
            r_addr1  <= '0;
        end else begin
            r_csb0 <= ~w_gnt;
            r_web0 <= ~(w_gnt & w_we);
            if (w_gnt) begin
                r_wmask0 <= w_wmask;
                r_addr0  <= w_addr;
                r_din0   <= w_wdata;
            end
            r_csb1 <= ~w_c_acc;
            if (w_c_acc) begin
                r_addr1 <= req.c_addr;
            end
        end
    end

    // Stage 0 tracks the cycle the macro samples; stage 1 the cycle its read data is valid.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tag0        <= '{valid: 1'b0, owner: OWN_A, is_write: 1'b0};
            r_tag1        <= '{valid: 1'b0, owner: OWN_A, is_write: 1'b0};
            r_c_v0        <= 1'b0;
            r_c_v1        <= 1'b0;
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_c_rsp_valid <= 1'b0;
            r_a_rsp_rdata <= '0;
            r_b_rsp_rdata <= '0;
            r_c_rsp_rdata <= '0;
        end else begin
            r_tag0        <= '{valid: w_gnt, owner: (w_gnt_b ? OWN_B : OWN_A), is_write: w_we};
            r_tag1        <= r_tag0;
            r_c_v0        <= w_c_acc;
            r_c_v1        <= r_c_v0;
            r_a_rsp_valid <= r_tag1.valid && (r_tag1.owner == OWN_A);
            r_b_rsp_valid <= r_tag1.valid && (r_tag1.owner == OWN_B);
            r_a_rsp_rdata <= (r_tag1.valid && (r_tag1.owner == OWN_A) && !r_tag1.is_write)
                             ? sram_dout0 : '0;
            r_b_rsp_rdata <= (r_tag1.valid && (r_tag1.owner == OWN_B) && !r_tag1.is_write)
                             ? sram_dout0 : '0;
            r_c_rsp_valid <= r_c_v1;
            r_c_rsp_rdata <= r_c_v1 ? sram_dout1 : '0;
        end
    end

    assign sram_csb0       = r_csb0;
    assign sram_web0       = r_web0;
    assign sram_wmask0     = r_wmask0;
    assign sram_addr0      = r_addr0;
    assign sram_din0       = r_din0;
    assign sram_csb1       = r_csb1;
    assign sram_addr1      = r_addr1;
    assign req.a_rsp_valid = r_a_rsp_valid;
    assign req.a_rsp_rdata = r_a_rsp_rdata;
    assign req.b_rsp_valid = r_b_rsp_valid;
    assign req.b_rsp_rdata = r_b_rsp_rdata;
    assign req.c_rsp_valid = r_c_rsp_valid;
    assign req.c_rsp_rdata = r_c_rsp_rdata;

endmodule

// File: tb/tb_sram_1rw1r_access_ctrl.sv
// tb/tb_sram_1rw1r_access_ctrl.sv - directed table + sequence bench with a behavioural 1RW1R macro
module tb_sram_1rw1r_access_ctrl;
    import sram_1rw1r_access_ctrl_pkg::*;

    logic                  clk, rst;
    logic                  sram_csb0, sram_web0, sram_csb1;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_WIDTH-1:0] sram_addr0, sram_addr1;
    logic [DATA_WIDTH-1:0] sram_din0, sram_dout0, sram_dout1;

    int n_chk  = 0;
    int n_fail = 0;

    sram_1rw1r_access_ctrl_if bus ();

    sram_1rw1r_access_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req         (bus),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: inputs registered on posedge, array accessed on the following negedge.
    logic [DATA_WIDTH-1:0] mem [0:511];
    logic                  m_csb0, m_web0, m_csb1;
    logic [NUM_WMASKS-1:0] m_wmask0;
    logic [ADDR_WIDTH-1:0] m_addr0, m_addr1;
    logic [DATA_WIDTH-1:0] m_din0;

    always @(posedge clk) begin
        m_csb0   <= sram_csb0;
        m_web0   <= sram_web0;
        m_wmask0 <= sram_wmask0;
        m_addr0  <= sram_addr0;
        m_din0   <= sram_din0;
        m_csb1   <= sram_csb1;
        m_addr1  <= sram_addr1;
    end

    always @(negedge clk) begin
        if (m_csb0 === 1'b0 && m_web0 === 1'b0) begin
            for (int l = 0; l < NUM_WMASKS; l++)
                if (m_wmask0[l]) mem[m_addr0][l*8 +: 8] = m_din0[l*8 +: 8];
        end
        if (m_csb0 === 1'b0 && m_web0 === 1'b1) sram_dout0 <= mem[m_addr0];
        if (m_csb1 === 1'b0) sram_dout1 <= mem[m_addr1];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_wmask = 4'hF; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_valid = 1'b0; bus.b_we = 1'b0; bus.b_wmask = 4'hF; bus.b_addr = '0; bus.b_wdata = '0;
        bus.c_valid = 1'b0; bus.c_addr = '0;
    endtask

    // Single isolated access on port 0 with latency and response checks.
    task automatic access(input bit use_b, input bit we, input logic [3:0] mask,
                          input logic [8:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input string nm);
        @(negedge clk);
        if (use_b) begin
            bus.b_valid = 1'b1; bus.b_we = we; bus.b_wmask = mask; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_valid = 1'b1; bus.a_we = we; bus.a_wmask = mask; bus.a_addr = addr; bus.a_wdata = wdata;
        end
        #1 chk({nm, " ready"}, use_b ? bus.b_ready : bus.a_ready, 1);
        @(negedge clk);
        idle();
        chk({nm, " csb0"}, sram_csb0, 0);
        chk({nm, " web0"}, sram_web0, !we);
        chk({nm, " addr0"}, sram_addr0, addr);
        chk({nm, " rsp_valid k"}, use_b ? bus.b_rsp_valid : bus.a_rsp_valid, 0);
        @(negedge clk);
        chk({nm, " rsp_valid k+1"}, use_b ? bus.b_rsp_valid : bus.a_rsp_valid, 0);
        @(negedge clk);
        chk({nm, " rsp_valid k+2"}, use_b ? bus.b_rsp_valid : bus.a_rsp_valid, 1);
        chk({nm, " rsp_rdata"}, use_b ? bus.b_rsp_rdata : bus.a_rsp_rdata, exp_rd);
    endtask

    typedef struct {
        logic        av, bv, cv, awe;
        logic [8:0]  aaddr, baddr, caddr;
        logic [31:0] awdata;
        logic        ea, eb, ec;
        logic        ear, ebr, ecr;
        logic [31:0] eard, ebrd, ecrd;
    } vec_t;

    vec_t vecs [13];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA5A50000 | i;
        sram_dout0 = '0;
        sram_dout1 = '0;

        //            av    bv    cv    awe   aaddr   baddr   caddr   awdata        ea    eb    ec    ear   ebr   ecr   eard          ebrd          ecrd
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h001, 9'h002, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h003, 9'h002, 9'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h003, 9'h004, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 9'h004, 9'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A50001, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 9'h005, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'hA5A50002, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 9'h006, 9'h000, 9'h006, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A50003, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 9'h006, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'hA5A50004, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 9'h006, 9'h006, 9'h007, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'hA5A50005};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h006, 9'h000, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h12345678};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h12345678, 32'hA5A50007};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0};

        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst csb0", sram_csb0, 1);
        chk("rst csb1", sram_csb1, 1);
        chk("rst web0", sram_web0, 1);
        chk("rst addr0", sram_addr0, 0);
        chk("rst din0", sram_din0, 0);
        chk("rst wmask0", sram_wmask0, 0);
        chk("rst addr1", sram_addr1, 0);
        chk("rst rsp_valid", {bus.a_rsp_valid, bus.b_rsp_valid, bus.c_rsp_valid}, 0);
        chk("rst rsp_rdata", bus.a_rsp_rdata | bus.b_rsp_rdata | bus.c_rsp_rdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d a_rsp_valid", i), bus.a_rsp_valid, vecs[i].ear);
            chk($sformatf("row%0d b_rsp_valid", i), bus.b_rsp_valid, vecs[i].ebr);
            chk($sformatf("row%0d c_rsp_valid", i), bus.c_rsp_valid, vecs[i].ecr);
            if (vecs[i].ear) chk($sformatf("row%0d a_rsp_rdata", i), bus.a_rsp_rdata, vecs[i].eard);
            if (vecs[i].ebr) chk($sformatf("row%0d b_rsp_rdata", i), bus.b_rsp_rdata, vecs[i].ebrd);
            if (vecs[i].ecr) chk($sformatf("row%0d c_rsp_rdata", i), bus.c_rsp_rdata, vecs[i].ecrd);
            bus.a_valid = vecs[i].av; bus.a_we = vecs[i].awe; bus.a_addr = vecs[i].aaddr;
            bus.a_wdata = vecs[i].awdata; bus.a_wmask = 4'hF;
            bus.b_valid = vecs[i].bv; bus.b_we = 1'b0; bus.b_addr = vecs[i].baddr;
            bus.c_valid = vecs[i].cv; bus.c_addr = vecs[i].caddr;
            #1;
            chk($sformatf("row%0d a_ready", i), bus.a_ready, vecs[i].ea);
            chk($sformatf("row%0d b_ready", i), bus.b_ready, vecs[i].eb);
            chk($sformatf("row%0d c_ready", i), bus.c_ready, vecs[i].ec);
        end
        idle();

        access(1'b0, 1'b1, 4'hF,    9'h010, 32'hDEADBEEF, 32'h0,        "a_wr_010");
        access(1'b0, 1'b0, 4'hF,    9'h010, 32'h0,        32'hDEADBEEF, "a_rd_010");
        access(1'b0, 1'b1, 4'hF,    9'h1FF, 32'h11223344, 32'h0,        "a_wr_1ff");
        access(1'b0, 1'b1, 4'b0010, 9'h1FF, 32'hAAAAAAAA, 32'h0,        "a_wr_1ff_mask");
        access(1'b1, 1'b0, 4'hF,    9'h1FF, 32'h0,        32'h1122AA44, "b_rd_1ff");
        access(1'b1, 1'b1, 4'h0,    9'h1FF, 32'hFFFFFFFF, 32'h0,        "b_wr_mask0");
        access(1'b0, 1'b0, 4'hF,    9'h1FF, 32'h0,        32'h1122AA44, "a_rd_1ff_after_mask0");

        // Two reads in flight with A as the last grant, then reset mid-cycle.
        @(negedge clk);
        bus.b_valid = 1'b1; bus.b_addr = 9'h010;
        @(negedge clk);
        bus.b_valid = 1'b0;
        bus.a_valid = 1'b1; bus.a_addr = 9'h1FF;
        #1 chk("inflight a_ready", bus.a_ready, 1);
        @(negedge clk);
        idle();
        chk("inflight csb0", sram_csb0, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst csb0", sram_csb0, 1);
        chk("midrst csb1", sram_csb1, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d rsp_valid", i), {bus.a_rsp_valid, bus.b_rsp_valid, bus.c_rsp_valid}, 0);
        end
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        #1;
        chk("postrst a_ready", bus.a_ready, 1);
        chk("postrst b_ready", bus.b_ready, 0);
        @(negedge clk);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
